// File: rtl/alu_pkg.sv
// Shared opcode constants and arbiter state encoding for the shared-ALU block.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; shift amounts use only the low log2(WIDTH) bits of b.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [SHW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = b[SHW-1:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Unassigned opcodes fall through to a zero result.
    always_comb begin
        result = '0;
        case (op)
            OPW'(OP_ADD):  result = a + b;
            OPW'(OP_SUB):  result = a - b;
            OPW'(OP_SLL):  result = a << shamt;
            OPW'(OP_SLT):  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OPW'(OP_SLTU): result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OPW'(OP_XOR):  result = a ^ b;
            OPW'(OP_SRL):  result = a >> shamt;
            OPW'(OP_SRA):  result = $signed(a) >>> shamt;
            OPW'(OP_OR):   result = a | b;
            OPW'(OP_AND):  result = a & b;
            default:       result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU through a single-entry result register with
// round-robin arbitration and back-to-back issue when the holder drains.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic             busy,
    output logic [15:0]      ops_done
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             owner;
    logic             owner_next;
    logic             ptr;
    logic             ptr_next;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_next;
    logic             zero_q;
    logic             zero_next;
    logic [15:0]      ops_done_next;

    logic             owner_ready;
    logic             slot_free;
    logic             consume;
    logic             grant;
    logic             grant_sel;

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    // ptr names the requester that wins the next tie.
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;
    assign consume     = (state == ST_FULL) && owner_ready;
    assign slot_free   = (state == ST_EMPTY) || owner_ready;
    assign grant       = rst_n && slot_free && (req0_valid || req1_valid);
    assign grant_sel   = (req0_valid && req1_valid) ? ptr : req1_valid;

    assign alu_op = grant_sel ? req1_op : req0_op;
    assign alu_a  = grant_sel ? req1_a  : req0_a;
    assign alu_b  = grant_sel ? req1_b  : req0_b;

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            owner    <= 1'b0;
            ptr      <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ops_done <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            ptr      <= ptr_next;
            result_q <= result_next;
            zero_q   <= zero_next;
            ops_done <= ops_done_next;
        end
    end

    // A drain and a new grant in the same cycle leave the slot FULL.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        ptr_next      = ptr;
        result_next   = result_q;
        zero_next     = zero_q;
        ops_done_next = ops_done;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        if (consume) begin
            state_next    = ST_EMPTY;
            ops_done_next = ops_done + 16'd1;
        end

        if (grant) begin
            req0_ready  = !grant_sel;
            req1_ready  = grant_sel;
            state_next  = ST_FULL;
            owner_next  = grant_sel;
            ptr_next    = !grant_sel;
            result_next = alu_result;
            zero_next   = alu_zero;
        end
    end

    assign busy        = (state == ST_FULL);
    assign rsp0_valid  = (state == ST_FULL) && !owner;
    assign rsp1_valid  = (state == ST_FULL) && owner;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter OPW, default 4: opcode width.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-008 reqN_a, reqN_b  input  WIDTH  operands of requester N.
REQ-009 reqN_op  input  OPW  ALU opcode of requester N.
REQ-010 rspN_valid  output  1  result for requester N held in the output register.
REQ-011 rspN_ready  input  1  requester N consumes its result.
REQ-012 rspN_result  output  WIDTH  registered ALU result; meaningful only while rspN_valid.
REQ-013 rspN_zero  output  1  registered zero flag; meaningful only while rspN_valid.
REQ-014 busy  output  1  high while a result is held (state FULL).
REQ-015 ops_done  output  16  count of results consumed; wraps 0xFFFF->0x0000.

Function
REQ-016 SHALL share one combinational ALU between two requesters, with at most one operation outstanding.
REQ-017 SHALL implement states EMPTY (no held result) and FULL (result held for owner O).
REQ-018 Slot free this cycle = EMPTY, or FULL with rspO_ready=1.
REQ-019 Grant when slot free and any reqN_valid: one valid requester wins; both valid: the requester not granted last wins (round-robin pointer).
REQ-020 reqN_ready=1 only for the granted requester, only in the grant cycle; combinational from valid, state and rspO_ready.
REQ-021 Pointer updates only on a grant; no requests leaves it unchanged.
REQ-022 Latency: operation granted at edge t -> rspN_valid=1, result and zero registered at t+1.
REQ-023 Held result, zero flag and owner stay stable until rspO_ready=1; other responder's valid stays 0.
REQ-024 FULL with rspO_ready=1 and a new grant: next state FULL with the new result (back-to-back, no bubble).
REQ-025 FULL with rspO_ready=1 and no grant: next state EMPTY.
REQ-026 rspN_ready while rspN_valid=0 is ignored.
REQ-027 ops_done increments by 1 on each cycle with rspO_valid and rspO_ready both 1.
REQ-028 Operands and opcode forwarded unmodified; undefined opcodes yield result 0, zero=1 per the ALU.

Reset
REQ-029 rst_n=0 at an edge: state EMPTY, all rspN_valid=0, results 0, zero 0, busy 0, ops_done 0, pointer favours requester 0.
REQ-030 Reset mid-operation discards held result without counting it; reqN_ready=0 in every cycle rst_n=0.

Structure
REQ-031 Opcode constants (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9) and state encoding in shared package alu_pkg.
REQ-032 SHALL instantiate the existing ALU as its single sub-module, fed from a 2:1 operand/opcode mux on the grant.
REQ-033 Target 120-400 lines RTL; no further sub-modules.

Verification
REQ-034 Single request: req0 a=5,b=3,op=ADD, rsp0_ready=1 -> req0_ready same cycle, next cycle rsp0_valid=1, result 8, zero 0, ops_done 1.
REQ-035 Contention: both valid every cycle (req0 SUB 7-7, req1 OR 1|2), both rsp ready -> grants alternate 0,1,0,1 from reset; rsp0 result 0/zero 1, rsp1 result 3.
REQ-036 Backpressure: rsp1_ready=0 for 4 cycles after result -> result stable, busy=1, both reqN_ready=0; on release, pending req0 granted same cycle, rsp0_valid next cycle.
REQ-037 Reset mid-op: rst_n=0 while FULL -> next edge rspN_valid=0, busy=0, ops_done=0; first later contention grants requester 0.
REQ-038 Counter wrap: force 65536 consumed results -> ops_done reads 0x0000 after the last.
REQ-039 Illegal opcode 4'hF with a=1,b=1 -> result 0, zero 1, handshake unaffected.
